// File: rtl/spi_weight_tx.sv
// -----------------------------------------------------------------------------
// spi_weight_tx
// SPI master (mode 0, active-low SS) that delivers beamformer weight/config
// words to the BF_TOP weight-load slave. The host pushes words through a
// valid/ready handshake into a small FIFO. Each word goes out MSB-first as one
// SS-framed transfer.
//
// Ports
//   clk       in   1       system clock, rising edge
//   rst_n     in   1       asynchronous active-low reset
//   soft_clr  in   1       synchronous abort/flush, active-high
//   tx_data   in   DATA_W  word to send
//   tx_valid  in   1       tx_data valid
//   tx_ready  out  1       FIFO can accept a word (not full)
//   sclk      out  1       SPI clock, idles low
//   mosi      out  1       SPI data, MSB first
//   ss        out  1       slave select, active-low
//   busy      out  1       frame in progress or FIFO non-empty
//   done      out  1       one-cycle pulse when a frame completes
// -----------------------------------------------------------------------------
module spi_weight_tx #(
  parameter int DATA_W     = 32,
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYC    = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              soft_clr,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              sclk,
  output logic              mosi,
  output logic              ss,
  output logic              busy,
  output logic              done
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNTF_W  = PTR_W + 1;
  localparam int CNT_MAX = (CLK_DIV > GAP_CYC) ? CLK_DIV : GAP_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int BIT_W   = $clog2(DATA_W);

  localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W-1:0]  PTR_ZERO  = PTR_W'(0);
  localparam logic [CNTF_W-1:0] FILL_ONE  = CNTF_W'(1);
  localparam logic [CNTF_W-1:0] FILL_ZERO = CNTF_W'(0);
  localparam logic [CNTF_W-1:0] FILL_FULL = CNTF_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0]  DIV_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(GAP_CYC - 1);
  localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);
  localparam logic [BIT_W-1:0]  BIT_ZERO  = BIT_W'(0);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);
  localparam logic [DATA_W-1:0] WORD_ZERO = {DATA_W{1'b0}};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEAD  = 3'd1,
    ST_HIGH  = 3'd2,
    ST_LOW   = 3'd3,
    ST_TRAIL = 3'd4,
    ST_GAP   = 3'd5
  } state_t;

  // FIFO storage and bookkeeping
  logic [DATA_W-1:0] mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNTF_W-1:0] fill_r;
  logic [DATA_W-1:0] rd_data_s;
  logic              push_s;
  logic              pop_s;

  // Serializer state
  state_t            state_r, state_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s, cnt_inc_s;
  logic [BIT_W-1:0]  bit_r, bit_s;
  logic [DATA_W-1:0] shift_r, shift_s;
  logic              sclk_r, sclk_s;
  logic              mosi_r, mosi_s;
  logic              ss_r, ss_s;
  logic              done_r, done_s;

  assign tx_ready  = (fill_r != FILL_FULL);
  assign push_s    = tx_valid && tx_ready && !soft_clr;
  // Words are only taken from the FIFO in IDLE; there is no bypass path.
  assign pop_s     = (state_r == ST_IDLE) && (fill_r != FILL_ZERO) && !soft_clr;
  assign rd_data_s = mem_r[rd_ptr_r];
  assign cnt_inc_s = cnt_r + CNT_ONE;

  // FIFO data array write port
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= tx_data;
    end
  end

  // FIFO pointers and fill level; pointers wrap naturally at FIFO_DEPTH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      fill_r   <= FILL_ZERO;
    end else if (soft_clr) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      fill_r   <= FILL_ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   fill_r <= fill_r + FILL_ONE;
        2'b01:   fill_r <= fill_r - FILL_ONE;
        default: fill_r <= fill_r;
      endcase
    end
  end

  // Serializer state register and registered SPI outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
      bit_r   <= BIT_ZERO;
      shift_r <= WORD_ZERO;
      sclk_r  <= 1'b0;
      mosi_r  <= 1'b0;
      ss_r    <= 1'b1;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      bit_r   <= bit_s;
      shift_r <= shift_s;
      sclk_r  <= sclk_s;
      mosi_r  <= mosi_s;
      ss_r    <= ss_s;
      done_r  <= done_s;
    end
  end

  // Serializer next-state and next-output logic
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    bit_s   = bit_r;
    shift_s = shift_r;
    sclk_s  = sclk_r;
    mosi_s  = mosi_r;
    ss_s    = ss_r;
    done_s  = 1'b0;
    if (soft_clr) begin
      state_s = ST_IDLE;
      cnt_s   = CNT_ZERO;
      bit_s   = BIT_ZERO;
      shift_s = WORD_ZERO;
      sclk_s  = 1'b0;
      mosi_s  = 1'b0;
      ss_s    = 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          sclk_s = 1'b0;
          ss_s   = 1'b1;
          if (pop_s) begin
            // First bit is presented together with the SS falling edge.
            shift_s = rd_data_s;
            mosi_s  = rd_data_s[DATA_W-1];
            ss_s    = 1'b0;
            bit_s   = BIT_ZERO;
            cnt_s   = CNT_ZERO;
            state_s = ST_LEAD;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_LEAD, ST_LOW: begin
          if (cnt_r == DIV_LAST) begin
            sclk_s  = 1'b1;
            cnt_s   = CNT_ZERO;
            state_s = ST_HIGH;
          end else begin
            cnt_s = cnt_inc_s;
          end
        end
        ST_HIGH: begin
          if (cnt_r == DIV_LAST) begin
            sclk_s = 1'b0;
            cnt_s  = CNT_ZERO;
            if (bit_r == BIT_LAST) begin
              state_s = ST_TRAIL;
            end else begin
              // Data advances on the falling SCLK edge so it is stable at the next rise.
              shift_s = {shift_r[DATA_W-2:0], 1'b0};
              mosi_s  = shift_r[DATA_W-2];
              bit_s   = bit_r + BIT_ONE;
              state_s = ST_LOW;
            end
          end else begin
            cnt_s = cnt_inc_s;
          end
        end
        ST_TRAIL: begin
          if (cnt_r == DIV_LAST) begin
            ss_s    = 1'b1;
            done_s  = 1'b1;
            mosi_s  = 1'b0;
            cnt_s   = CNT_ZERO;
            state_s = ST_GAP;
          end else begin
            cnt_s = cnt_inc_s;
          end
        end
        ST_GAP: begin
          if (cnt_r == GAP_LAST) begin
            cnt_s   = CNT_ZERO;
            state_s = ST_IDLE;
          end else begin
            cnt_s = cnt_inc_s;
          end
        end
        default: begin
          // Unreachable encodings recover to a clean idle bus.
          state_s = ST_IDLE;
          cnt_s   = CNT_ZERO;
          bit_s   = BIT_ZERO;
          sclk_s  = 1'b0;
          mosi_s  = 1'b0;
          ss_s    = 1'b1;
        end
      endcase
    end
  end

  assign sclk = sclk_r;
  assign mosi = mosi_r;
  assign ss   = ss_r;
  assign done = done_r;
  assign busy = (state_r != ST_IDLE) || (fill_r != FILL_ZERO);

endmodule

// File: tb/tb_spi_weight_tx.sv
// -----------------------------------------------------------------------------
// tb_spi_weight_tx
// Self-checking bench for spi_weight_tx. Instance dut uses the default
// parameters; instance dut_b uses DATA_W=8, CLK_DIV=1. Accepted words are
// queued in a scoreboard and compared against the frames reconstructed from
// SCLK/MOSI/SS by a negedge monitor.
// -----------------------------------------------------------------------------
module tb_spi_weight_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        soft_clr = 1'b0;
  logic        tx_valid = 1'b0;
  logic [31:0] tx_data = 32'h0;
  logic        tx_ready, sclk, mosi, ss, busy, done;

  logic        soft_clr_b = 1'b0;
  logic        tx_valid_b = 1'b0;
  logic [7:0]  tx_data_b = 8'h0;
  logic        tx_ready_b, sclk_b, mosi_b, ss_b, busy_b, done_b;

  int          n_checks = 0;
  int          n_errors = 0;
  int          abort_req = 0;
  bit          gap_chk_en = 1'b0;
  logic [31:0] sb [$];

  always #5 clk = ~clk;

  spi_weight_tx dut (
    .clk(clk), .rst_n(rst_n), .soft_clr(soft_clr),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .sclk(sclk), .mosi(mosi), .ss(ss), .busy(busy), .done(done)
  );

  spi_weight_tx #(.DATA_W(8), .CLK_DIV(1), .GAP_CYC(2), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .soft_clr(soft_clr_b),
    .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
    .sclk(sclk_b), .mosi(mosi_b), .ss(ss_b), .busy(busy_b), .done(done_b)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- monitor for the default instance ----------------
  int          rise_cnt = 0, low_len = 0, high_len = 0;
  int          frame_starts = 0, frames_ok = 0, done_cnt = 0, abort_seen = 0;
  logic [31:0] acc = 32'h0;
  logic        ss_q = 1'b1, sclk_q = 1'b0, mosi_q = 1'b0;
  bit          gap_track = 1'b0;

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (ss === 1'b0) begin
      if (ss_q === 1'b1) begin
        frame_starts++;
        rise_cnt = 0;
        low_len  = 0;
        acc      = 32'h0;
        if (gap_chk_en && gap_track) check_val("gap_ss_high", high_len, 9);
        gap_track = 1'b0;
      end
      low_len++;
      if (sclk === 1'b1 && sclk_q === 1'b0) begin
        if (ss_q === 1'b0) check_val("mosi_stable_at_rise", mosi, mosi_q);
        rise_cnt++;
        acc = {acc[30:0], mosi};
      end
    end else begin
      if (ss_q === 1'b0) begin
        if (abort_seen != abort_req) begin
          abort_seen = abort_req;
          gap_track  = 1'b0;
        end else begin
          frames_ok++;
          check_val("frame_rises", rise_cnt, 32);
          check_val("frame_ss_low", low_len, 260);
          check_val("done_with_ss_rise", done, 1'b1);
          if (sb.size() == 0) check_val("sb_underflow", sb.size(), 1);
          else check_val("frame_data", acc, sb.pop_front());
          gap_track = 1'b1;
        end
        rise_cnt = 0;
        high_len = 0;
      end
      high_len++;
    end
    ss_q   = ss;
    sclk_q = sclk;
    mosi_q = mosi;
  end

  // ---------------- stimulus helpers ----------------
  task automatic push_word(input logic [31:0] w);
    int n = 0;
    while (tx_ready !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (tx_ready !== 1'b1) begin
      check_val("push_ready_timeout", tx_ready, 1'b1);
    end else begin
      tx_data  = w;
      tx_valid = 1'b1;
      sb.push_back(w);
      @(posedge clk);
      #1;
      tx_valid = 1'b0;
    end
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    @(negedge clk);
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_val("done_seen", done, 1'b1);
  endtask

  task automatic wait_rises(input int target);
    int n = 0;
    while (rise_cnt != target && n < 400) begin
      @(negedge clk);
      #2;
      n++;
    end
    check_val("reach_rise", rise_cnt, target);
  endtask

  task automatic run_b(input logic [7:0] w);
    int lowc = 0, rises = 0, badper = 0, last = -1, n = 0;
    logic [7:0] accb = 8'h0;
    logic prev = 1'b0, done_end = 1'b0;
    bit started = 1'b0, ended = 1'b0;
    check_val("b_ready", tx_ready_b, 1'b1);
    @(negedge clk);
    tx_data_b  = w;
    tx_valid_b = 1'b1;
    @(posedge clk);
    #1;
    tx_valid_b = 1'b0;
    while (!ended && n < 100) begin
      @(negedge clk);
      if (ss_b === 1'b0) begin
        started = 1'b1;
        lowc++;
        if (sclk_b === 1'b1 && prev === 1'b0) begin
          if (last >= 0 && (n - last) != 2) badper++;
          last = n;
          rises++;
          accb = {accb[6:0], mosi_b};
        end
      end else if (started) begin
        ended    = 1'b1;
        done_end = done_b;
      end
      prev = sclk_b;
      n++;
    end
    check_val("b_frame_end", ended, 1'b1);
    check_val("b_ss_low", lowc, 17);
    check_val("b_rises", rises, 8);
    check_val("b_data", accb, w);
    check_val("b_sclk_period", badper, 0);
    check_val("b_done", done_end, 1'b1);
    repeat (5) @(negedge clk);
    check_val("b_busy_idle", busy_b, 1'b0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int starts0, dones0, n;
    logic [31:0] words [5];
    words[0] = 32'h1111_0001; words[1] = 32'h8000_0001; words[2] = 32'h7FFF_FFFE;
    words[3] = 32'hCAFE_F00D; words[4] = 32'h0123_4567;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("rst_ss", ss, 1'b1);
    check_val("rst_sclk", sclk, 1'b0);
    check_val("rst_mosi", mosi, 1'b0);
    check_val("rst_done", done, 1'b0);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_ready", tx_ready, 1'b1);

    // single word, latency and framing
    push_word(32'hA5C3_0F81);
    check_val("ss_before_pop", ss, 1'b1);
    check_val("busy_after_push", busy, 1'b1);
    @(posedge clk); #1;
    check_val("ss_after_pop", ss, 1'b0);
    wait_done(400);

    // narrow fast configuration
    run_b(8'h01);
    run_b(8'hB4);

    // back-to-back words, full FIFO, dropped forced push
    @(negedge clk);
    for (int i = 0; i < 5; i++) push_word(words[i]);
    check_val("ready_full", tx_ready, 1'b0);
    gap_chk_en = 1'b1;
    tx_data  = 32'hDEAD_BEEF;
    tx_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tx_valid = 1'b0;
    check_val("ready_full_forced", tx_ready, 1'b0);
    wait_done(400);
    check_val("ready_at_done", tx_ready, 1'b0);
    repeat (8) @(posedge clk); #1;
    check_val("ready_before_pop", tx_ready, 1'b0);
    @(posedge clk); #1;
    check_val("ready_after_pop", tx_ready, 1'b1);
    for (int i = 0; i < 4; i++) wait_done(400);
    check_val("busy_at_last_done", busy, 1'b1);
    gap_chk_en = 1'b0;
    repeat (8) @(posedge clk); #1;
    check_val("busy_after_gap", busy, 1'b0);
    check_val("sb_drained_b2b", sb.size(), 0);

    // asynchronous reset on the 10th SCLK rise
    @(negedge clk);
    push_word(32'h3C5A_9617);
    wait_rises(10);
    abort_req++;
    rst_n = 1'b0;
    #1;
    check_val("arst_ss", ss, 1'b1);
    check_val("arst_sclk", sclk, 1'b0);
    check_val("arst_mosi", mosi, 1'b0);
    check_val("arst_busy", busy, 1'b0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    starts0 = frame_starts;
    repeat (300) @(negedge clk);
    check_val("no_frame_after_rst", frame_starts, starts0);

    // soft clear mid-frame with two words queued and a same-cycle push
    push_word(32'hAAAA_5555);
    push_word(32'h5555_AAAA);
    push_word(32'h0F0F_F0F0);
    wait_rises(5);
    abort_req++;
    soft_clr = 1'b1;
    tx_data  = 32'h1234_5678;
    tx_valid = 1'b1;
    @(posedge clk); #1;
    soft_clr = 1'b0;
    tx_valid = 1'b0;
    check_val("sclr_ss", ss, 1'b1);
    check_val("sclr_sclk", sclk, 1'b0);
    check_val("sclr_mosi", mosi, 1'b0);
    check_val("sclr_done", done, 1'b0);
    check_val("sclr_ready", tx_ready, 1'b1);
    check_val("sclr_busy", busy, 1'b0);
    sb.delete();
    starts0 = frame_starts;
    dones0  = done_cnt;
    repeat (400) @(negedge clk);
    check_val("sclr_no_frame", frame_starts, starts0);
    check_val("sclr_no_done", done_cnt, dones0);

    // push during GAP with empty FIFO, then enough words to wrap the pointers
    @(negedge clk);
    push_word(32'h0F1E_2D3C);
    wait_done(400);
    push_word(32'h4B5A_6978);
    repeat (7) @(posedge clk); #1;
    check_val("gap_no_early_start", ss, 1'b1);
    @(posedge clk); #1;
    check_val("gap_start_after_idle", ss, 1'b0);
    for (int i = 0; i < 8; i++) push_word((32'h9E37_79B9 * (i + 1)) ^ 32'h00FF_00FF);
    n = 0;
    while ((sb.size() != 0 || busy !== 1'b0) && n < 6000) begin
      @(negedge clk);
      n++;
    end
    check_val("wrap_drained", sb.size(), 0);
    check_val("wrap_busy_low", busy, 1'b0);
    check_val("done_per_frame", done_cnt, frames_ok);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
